// File: rtl/frame_seq_pkg.sv
// rtl/frame_seq_pkg.sv - shared state encoding and exposure helper for the frame sequencer
package frame_seq_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXPOSE  = 2'd1;
  localparam logic [1:0] ST_READOUT = 2'd2;
  localparam logic [1:0] ST_GAP     = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_EXPOSE  = ST_EXPOSE,
    S_READOUT = ST_READOUT,
    S_GAP     = ST_GAP
  } seq_state_t;

  // A zero exposure request would give an empty window; run one line-time instead.
  function automatic logic [31:0] clamp_one(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/line_timer.sv
// rtl/line_timer.sv - counts N line-times of LINE_CLKS cycles and pulses done on the last cycle
module line_timer #(
  parameter int LINE_CLKS = 1000,
  parameter int EXP_W     = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [EXP_W-1:0] lines,
  output logic             done
);

  localparam int CW = (LINE_CLKS > 1) ? $clog2(LINE_CLKS) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(LINE_CLKS - 1);

  logic [CW-1:0]    clk_cnt;
  logic [EXP_W-1:0] line_cnt;
  logic [EXP_W-1:0] line_last;

  // done is combinational so the owner can leave the window on the final counted cycle.
  assign done = en && (clk_cnt == CLK_LAST) && (line_cnt == line_last);

  // load captures the line count (must be >= 1) and restarts both counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt   <= '0;
      line_cnt  <= '0;
      line_last <= '0;
    end else if (load) begin
      clk_cnt   <= '0;
      line_cnt  <= '0;
      line_last <= lines - 1'b1;
    end else if (en) begin
      if (clk_cnt == CLK_LAST) begin
        clk_cnt  <= '0;
        line_cnt <= done ? '0 : line_cnt + 1'b1;
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_seq_ctrl.sv
// rtl/frame_seq_ctrl.sv - frame-request sequencer: exposure windows, readout tracking, timeout, abort
module frame_seq_ctrl
  import frame_seq_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int EXP_W     = 13,
  parameter int LINE_CLKS = 1000,
  parameter int GAP_CLKS  = 16,
  parameter int TO_CLKS   = 2000000
) (
  input  logic             clk_rxg,
  input  logic             rst_rx_n,
  input  logic             frame_req,
  input  logic [CNT_W-1:0] frame_req_cnt,
  input  logic [EXP_W-1:0] exp_line_time_req,
  input  logic             rd_frame_done,
  input  logic             abort,
  output logic             exp_active,
  output logic             frame_start,
  output logic             frame_end,
  output logic [CNT_W-1:0] frame_idx,
  output logic             busy,
  output logic             seq_done,
  output logic             timeout_err
);

  localparam int TW = $clog2(TO_CLKS + 1);
  localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TO_CLKS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS - 1);

  seq_state_t       state;
  logic             frame_req_d;
  logic [CNT_W-1:0] cnt_lat;
  logic [TW-1:0]    to_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             rise;
  logic [CNT_W-1:0] idx_next;
  logic [EXP_W-1:0] exp_clamped;
  logic             tmr_load;
  logic             tmr_en;
  logic             tmr_done;

  assign rise        = frame_req & ~frame_req_d;
  assign idx_next    = frame_idx + 1'b1;
  assign exp_clamped = EXP_W'(clamp_one(32'(exp_line_time_req)));
  assign tmr_en      = (state == S_EXPOSE);
  // The exposure is (re)latched into the timer exactly when a window is about to open;
  // abort also reloads it so the counters restart from zero.
  assign tmr_load    = abort
                     | ((state == S_IDLE) & rise)
                     | ((state == S_GAP) & (gap_cnt == GAP_LAST));

  line_timer #(
    .LINE_CLKS (LINE_CLKS),
    .EXP_W     (EXP_W)
  ) u_exp_timer (
    .clk   (clk_rxg),
    .rst_n (rst_rx_n),
    .load  (tmr_load),
    .en    (tmr_en),
    .lines (exp_clamped),
    .done  (tmr_done)
  );

  // Sequencer FSM with registered outputs; abort overrides every state.
  always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
    if (!rst_rx_n) begin
      state       <= S_IDLE;
      frame_req_d <= 1'b0;
      cnt_lat     <= '0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      exp_active  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_idx   <= '0;
      busy        <= 1'b0;
      seq_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      frame_req_d <= frame_req;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      seq_done    <= 1'b0;
      if (abort) begin
        state      <= S_IDLE;
        exp_active <= 1'b0;
        busy       <= 1'b0;
        to_cnt     <= '0;
        gap_cnt    <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (rise) begin
              cnt_lat     <= frame_req_cnt;
              frame_idx   <= '0;
              timeout_err <= 1'b0;
              state       <= S_EXPOSE;
              exp_active  <= 1'b1;
              frame_start <= 1'b1;
              busy        <= 1'b1;
            end
          end
          S_EXPOSE: begin
            if (tmr_done) begin
              state      <= S_READOUT;
              exp_active <= 1'b0;
              to_cnt     <= '0;
            end
          end
          S_READOUT: begin
            // A completion arriving on the expiry cycle still counts as a good frame.
            if (rd_frame_done) begin
              frame_end <= 1'b1;
              frame_idx <= idx_next;
              if (((cnt_lat != '0) && (idx_next == cnt_lat)) ||
                  ((cnt_lat == '0) && !frame_req)) begin
                seq_done <= 1'b1;
                state    <= S_IDLE;
                busy     <= 1'b0;
              end else begin
                state   <= S_GAP;
                gap_cnt <= '0;
              end
            end else if (to_cnt == TO_LAST) begin
              timeout_err <= 1'b1;
              state       <= S_IDLE;
              busy        <= 1'b0;
              to_cnt      <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          S_GAP: begin
            if (gap_cnt == GAP_LAST) begin
              state       <= S_EXPOSE;
              exp_active  <= 1'b1;
              frame_start <= 1'b1;
              gap_cnt     <= '0;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// tb/tb_frame_seq_ctrl.sv - scoreboard bench for frame_seq_ctrl
module tb_frame_seq_ctrl;

  localparam int CNT_W = 8;
  localparam int EXP_W = 13;

  localparam int EV_START = 0, EV_GAP = 1, EV_WIN = 2, EV_END = 3, EV_DONE = 4, EV_TERR = 5;
  localparam int SG_EXP = 0, SG_BUSY = 1, SG_TERR = 2, SG_IDX = 3, SG_ALL = 4;

  typedef struct {
    int kind;
    int val;
  } item_t;

  logic             clk_rxg = 1'b0;
  logic             rst_rx_n = 1'b0;
  logic             frame_req = 1'b0;
  logic [CNT_W-1:0] frame_req_cnt = '0;
  logic [EXP_W-1:0] exp_line_time_req = '0;
  logic             rd_frame_done = 1'b0;
  logic             abort = 1'b0;
  logic             exp_active, frame_start, frame_end, busy, seq_done, timeout_err;
  logic [CNT_W-1:0] frame_idx;

  item_t exp_q[$];
  item_t snap_q[$];
  logic  fin = 1'b0;
  int    n_tests = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    win_len = 0;
  int    lowc = 0;
  int    last_end = 0;
  logic  prev_exp = 1'b0;
  logic  prev_terr = 1'b0;

  frame_seq_ctrl #(
    .CNT_W (CNT_W), .EXP_W (EXP_W), .LINE_CLKS (4), .GAP_CLKS (3), .TO_CLKS (50)
  ) dut (
    .clk_rxg           (clk_rxg),
    .rst_rx_n          (rst_rx_n),
    .frame_req         (frame_req),
    .frame_req_cnt     (frame_req_cnt),
    .exp_line_time_req (exp_line_time_req),
    .rd_frame_done     (rd_frame_done),
    .abort             (abort),
    .exp_active        (exp_active),
    .frame_start       (frame_start),
    .frame_end         (frame_end),
    .frame_idx         (frame_idx),
    .busy              (busy),
    .seq_done          (seq_done),
    .timeout_err       (timeout_err)
  );

  always #5 clk_rxg = ~clk_rxg;

  function automatic string ev_name(input int k);
    case (k)
      EV_START: return "frame_start(idx)";
      EV_GAP:   return "gap_cycles";
      EV_WIN:   return "exp_window_len";
      EV_END:   return "frame_end(idx)";
      EV_DONE:  return "seq_done(idx)";
      default:  return "timeout_err(cycles_in_readout)";
    endcase
  endfunction

  function automatic string sig_name(input int s);
    case (s)
      SG_EXP:  return "exp_active";
      SG_BUSY: return "busy";
      SG_TERR: return "timeout_err";
      SG_IDX:  return "frame_idx";
      default: return "all_outputs";
    endcase
  endfunction

  function automatic int sig_val(input int s);
    case (s)
      SG_EXP:  return int'(exp_active);
      SG_BUSY: return int'(busy);
      SG_TERR: return int'(timeout_err);
      SG_IDX:  return int'(frame_idx);
      default: return int'({exp_active, frame_start, frame_end, busy, seq_done, timeout_err, frame_idx});
    endcase
  endfunction

  task automatic push_ev(input int k, input int v);
    item_t it;
    it.kind = k;
    it.val  = v;
    exp_q.push_back(it);
  endtask

  task automatic snap(input int s, input int v);
    item_t it;
    it.kind = s;
    it.val  = v;
    snap_q.push_back(it);
  endtask

  task automatic sb_check(input int k, input int v);
    item_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected %s at cycle %0d: got %0d, expected no event", ev_name(k), cyc, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        n_fail++;
        $display("FAIL event at cycle %0d: got %s=%0d, expected %s=%0d", cyc, ev_name(k), v, ev_name(e.kind), e.val);
      end
    end
  endtask

  task automatic cmp(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  // Monitor: samples on the falling edge, turns DUT activity into events for the scoreboard.
  initial begin
    item_t it;
    forever begin
      @(negedge clk_rxg);
      cyc++;
      while (snap_q.size() > 0) begin
        it = snap_q.pop_front();
        cmp(sig_name(it.kind), sig_val(it.kind), it.val);
      end
      if (frame_start) begin
        if (frame_idx != '0) sb_check(EV_GAP, cyc - last_end);
        sb_check(EV_START, int'(frame_idx));
      end
      if (exp_active) win_len++;
      if (prev_exp && !exp_active) begin
        sb_check(EV_WIN, win_len);
        win_len = 0;
        lowc    = 0;
      end else if (!exp_active) begin
        lowc++;
      end
      if (frame_end) begin
        last_end = cyc;
        sb_check(EV_END, int'(frame_idx));
      end
      if (seq_done) sb_check(EV_DONE, int'(frame_idx));
      if (timeout_err && !prev_terr) sb_check(EV_TERR, lowc);
      prev_exp  = exp_active;
      prev_terr = timeout_err;
      if (fin || cyc > 20000) begin
        cmp("events_outstanding", exp_q.size(), 0);
        cmp("bench_watchdog", int'(cyc > 20000), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_rxg);
    #1;
  endtask

  task automatic wait_exp(input logic lvl, input int bound);
    int k = 0;
    while (exp_active !== lvl && k < bound) begin
      tick(1);
      k++;
    end
    snap(SG_EXP, int'(lvl));
  endtask

  task automatic pulse_rd();
    rd_frame_done = 1'b1;
    tick(1);
    rd_frame_done = 1'b0;
  endtask

  task automatic start_seq(input int cnt, input int expv);
    frame_req_cnt     = CNT_W'(cnt);
    exp_line_time_req = EXP_W'(expv);
    frame_req         = 1'b1;
    tick(1);
  endtask

  // Stimulus: directed scenarios; expected events are queued before each is driven.
  initial begin
    tick(2);
    snap(SG_ALL, 0);
    tick(1);
    rst_rx_n = 1'b1;
    tick(2);

    // single frame, exp=5
    push_ev(EV_START, 0); push_ev(EV_WIN, 20); push_ev(EV_END, 1); push_ev(EV_DONE, 1);
    start_seq(1, 5);
    snap(SG_EXP, 1);
    wait_exp(1'b0, 40);
    tick(10);
    pulse_rd();
    snap(SG_IDX, 1);
    tick(1);
    snap(SG_BUSY, 0);
    frame_req = 1'b0;
    tick(3);

    // burst of 3, exposure raised to 6 during frame 1 readout
    push_ev(EV_START, 0); push_ev(EV_WIN, 8);  push_ev(EV_END, 1);
    push_ev(EV_GAP, 3);   push_ev(EV_START, 1); push_ev(EV_WIN, 24); push_ev(EV_END, 2);
    push_ev(EV_GAP, 3);   push_ev(EV_START, 2); push_ev(EV_WIN, 24); push_ev(EV_END, 3);
    push_ev(EV_DONE, 3);
    start_seq(3, 2);
    for (int f = 0; f < 3; f++) begin
      if (f > 0) wait_exp(1'b1, 20);
      wait_exp(1'b0, 60);
      if (f == 0) exp_line_time_req = EXP_W'(6);
      tick(2);
      pulse_rd();
    end
    snap(SG_BUSY, 0);
    frame_req = 1'b0;
    tick(3);

    // continuous, stop requested during the 4th readout
    for (int f = 0; f < 4; f++) begin
      if (f > 0) push_ev(EV_GAP, 3);
      push_ev(EV_START, f); push_ev(EV_WIN, 4); push_ev(EV_END, f + 1);
    end
    push_ev(EV_DONE, 4);
    start_seq(0, 1);
    for (int f = 0; f < 4; f++) begin
      if (f > 0) wait_exp(1'b1, 20);
      wait_exp(1'b0, 20);
      if (f == 3) frame_req = 1'b0;
      tick(2);
      pulse_rd();
    end
    snap(SG_BUSY, 0);
    tick(10);
    snap(SG_BUSY, 0);
    snap(SG_EXP, 0);

    // readout timeout, then a new rise clears the flag
    push_ev(EV_START, 0); push_ev(EV_WIN, 4); push_ev(EV_TERR, 50);
    start_seq(2, 1);
    wait_exp(1'b0, 20);
    tick(49);
    snap(SG_TERR, 0);
    tick(1);
    snap(SG_TERR, 1);
    snap(SG_BUSY, 0);
    tick(5);
    frame_req = 1'b0;
    tick(1);
    // completion on the expiry cycle beats the timeout
    push_ev(EV_START, 0); push_ev(EV_WIN, 4); push_ev(EV_END, 1); push_ev(EV_DONE, 1);
    start_seq(1, 1);
    snap(SG_TERR, 0);
    wait_exp(1'b0, 20);
    tick(49);
    pulse_rd();
    snap(SG_TERR, 0);
    snap(SG_BUSY, 0);
    frame_req = 1'b0;
    tick(3);

    // abort in exposure cycle 3; a rise during abort is ignored
    push_ev(EV_START, 0); push_ev(EV_WIN, 3);
    start_seq(1, 2);
    tick(2);
    abort = 1'b1;
    tick(1);
    snap(SG_EXP, 0);
    snap(SG_BUSY, 0);
    snap(SG_IDX, 0);
    frame_req = 1'b0;
    tick(1);
    frame_req = 1'b1;
    tick(1);
    abort = 1'b0;
    snap(SG_BUSY, 0);
    tick(3);
    snap(SG_BUSY, 0);
    snap(SG_EXP, 0);
    frame_req = 1'b0;
    tick(2);

    // async reset in exposure cycle 3
    push_ev(EV_START, 0); push_ev(EV_WIN, 2);
    start_seq(1, 2);
    tick(2);
    rst_rx_n = 1'b0;
    snap(SG_ALL, 0);
    frame_req = 1'b0;
    tick(2);
    rst_rx_n = 1'b1;
    tick(2);

    // exp=0 runs one line-time; rise while busy and stray readout pulses are ignored
    push_ev(EV_START, 0); push_ev(EV_WIN, 4); push_ev(EV_END, 1); push_ev(EV_DONE, 1);
    start_seq(1, 0);
    frame_req = 1'b0;
    tick(1);
    frame_req = 1'b1;
    tick(1);
    pulse_rd();
    wait_exp(1'b0, 20);
    tick(2);
    pulse_rd();
    frame_req = 1'b0;
    tick(2);
    pulse_rd();
    tick(5);
    snap(SG_BUSY, 0);
    snap(SG_IDX, 1);

    tick(2);
    fin = 1'b1;
  end

endmodule
